blink_mode_ctrl: RTL

- Front-panel control stage that sits directly upstream of the LED blinker and drives its enable, sel0 and sel1 inputs.
- Takes two raw push-buttons, mode_btn and en_btn. Each is synchronised, debounced and rising-edge detected.
- A mode_btn press steps the blink rate 1 Hz -> 10 Hz -> 50 Hz -> 100 Hz -> 1 Hz.
- An en_btn press toggles the blinker enable.
- Runs on the same 25 kHz system clock.

---
 rtl/blink_pkg.sv | 22 ++
 rtl/blink_mode_ctrl_if.sv | 19 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/blink_mode_ctrl.sv | 62 ++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blinker front-panel control.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_1HZ   = 2'b00,
        MODE_10HZ  = 2'b01,
        MODE_50HZ  = 2'b10,
        MODE_100HZ = 2'b11
    } blink_mode_t;

    localparam int CLK_HZ      = 25000;
    localparam int DEBOUNCE_MS = 20;
    localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Step the blink rate, wrapping from 100 Hz back to 1 Hz.
    function automatic blink_mode_t next_mode(input blink_mode_t m);
        logic [1:0] nxt;
        nxt = m + 2'd1;
        return blink_mode_t'(nxt);
    endfunction

endpackage

// File: rtl/blink_mode_ctrl_if.sv
// Button inputs and blinker-control outputs of the front-panel stage.
interface blink_mode_ctrl_if;
    logic mode_btn;
    logic en_btn;
    logic enable;
    logic sel0;
    logic sel1;
    logic mode_pulse;

    modport master (
        output mode_btn, en_btn,
        input  enable, sel0, sel1, mode_pulse
    );

    modport slave (
        input  mode_btn, en_btn,
        output enable, sel0, sel1, mode_pulse
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counting debouncer and one-cycle press strobe
// for a single raw push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        s1;
    logic        s;
    logic [15:0] cnt;

    // The strobe fires on the same edge db is accepted high, so the
    // consumer register updates one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s      <= 1'b0;
            cnt    <= '0;
            btn_db <= 1'b0;
            press  <= 1'b0;
        end else begin
            s1    <= btn_raw;
            s     <= s1;
            press <= 1'b0;
            if (s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_db <= s;
                cnt    <= '0;
                press  <= s;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/blink_mode_ctrl.sv
// Front-panel control: debounced mode/enable buttons drive the blinker's
// enable and rate-select inputs.
module blink_mode_ctrl
    import blink_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic       RESET_ENABLE    = 1'b1,
    parameter logic [1:0] RESET_MODE      = 2'b00
) (
    input logic                clk,
    input logic                rst,
    blink_mode_ctrl_if.slave   bus
);

    logic        mode_db;
    logic        mode_press;
    logic        en_db;
    logic        en_press;
    blink_mode_t mode;
    logic        enable;
    logic        mode_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.mode_btn),
        .btn_db  (mode_db),
        .press   (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.en_btn),
        .btn_db  (en_db),
        .press   (en_press)
    );

    // Both actions are independent, so simultaneous presses land on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= blink_mode_t'(RESET_MODE);
            enable     <= RESET_ENABLE;
            mode_pulse <= 1'b0;
        end else begin
            mode_pulse <= 1'b0;
            if (mode_press && mode_db) begin
                mode       <= next_mode(mode);
                mode_pulse <= 1'b1;
            end
            if (en_press && en_db) begin
                enable <= ~enable;
            end
        end
    end

    assign bus.enable     = enable;
    assign bus.sel0       = mode[1];
    assign bus.sel1       = mode[0];
    assign bus.mode_pulse = mode_pulse;

endmodule
